go_initiator_3: RTL and testbench

GO_INITIATOR_3 -- requirements
Module: go_initiator_3

---
 rtl/go_initiator_3_pkg.sv | 16 +
 rtl/go_initiator_3_ch.sv | 82 ++++++++
 rtl/go_initiator_3.sv | 75 +++++++
 tb/tb_go_initiator_3.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/go_initiator_3_pkg.sv
// Shared constants and types for the three-channel go/kill initiator.
// Channel state encoding and default timeout live here so every block agrees.
package go_initiator_3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GO   = 2'd1,
      ST_WAIT = 2'd2,
      ST_KILL = 2'd3
   } ch_state_t;

   localparam int TIMEOUT_DEFAULT = 16;
   localparam int CNT_W_DEFAULT   = 8;
   localparam int NUM_CH          = 3;

endpackage

// File: rtl/go_initiator_3_ch.sv
// One initiator channel: IDLE -> GO -> WAIT -> (IDLE | KILL -> IDLE) with a
// saturating wait counter. Outputs are registered from the next-state decode.
module go_initiator_ch
   import go_initiator_3_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      req,
   input  logic      abort,
   input  logic      done,
   output logic      go,
   output logic      kill,
   output logic      busy,
   output logic      timeout_kill,
   output ch_state_t state
);

   // Handshake: req is level-sampled only in IDLE; done/abort matter only in
   // WAIT. go and kill are one-cycle pulses that mirror the GO and KILL states.

   ch_state_t        next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;
   logic             timeout_hit;

   always_comb begin
      next_state  = state;
      next_cnt    = cnt;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req) next_state = ST_GO;
         end
         ST_GO: begin
            next_cnt   = '0;
            next_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (done) begin
               next_state = ST_IDLE;
            end else if (abort) begin
               next_state = ST_KILL;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               next_state  = ST_KILL;
               timeout_hit = 1'b1;
            end else begin
               next_cnt = cnt + CNT_W'(1);
            end
         end
         ST_KILL: begin
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // timeout_kill rides along with the kill pulse so the sticky flag rises
   // the cycle after the kill.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         go           <= 1'b0;
         kill         <= 1'b0;
         busy         <= 1'b0;
         timeout_kill <= 1'b0;
      end else begin
         state        <= next_state;
         cnt          <= next_cnt;
         go           <= (next_state == ST_GO);
         kill         <= (next_state == ST_KILL);
         busy         <= (next_state != ST_IDLE);
         timeout_kill <= timeout_hit;
      end
   end

endmodule

// File: rtl/go_initiator_3.sv
// Three independent go/kill initiator channels with a shared abort, a packed
// busy vector and a sticky timeout flag.
module go_initiator_3
   import go_initiator_3_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic       abort,
   input  logic       done_1,
   input  logic       done_2,
   input  logic       done_3,
   input  logic       kill_clr,
   output logic       go_1,
   output logic       go_2,
   output logic       go_3,
   output logic       kill_1,
   output logic       kill_2,
   output logic       kill_3,
   output logic [2:0] busy,
   output logic       timeout_ltchd,
   output logic [5:0] state_dbg
);

   logic [2:0] done_v;
   logic [2:0] go_v;
   logic [2:0] kill_v;
   logic [2:0] busy_v;
   logic [2:0] tkill_v;
   ch_state_t  ch_state [NUM_CH];

   assign done_v = {done_3, done_2, done_1};

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      go_initiator_ch #(
         .TIMEOUT (TIMEOUT),
         .CNT_W   (CNT_W)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .req          (req[i]),
         .abort        (abort),
         .done         (done_v[i]),
         .go           (go_v[i]),
         .kill         (kill_v[i]),
         .busy         (busy_v[i]),
         .timeout_kill (tkill_v[i]),
         .state        (ch_state[i])
      );
   end

   assign go_1      = go_v[0];
   assign go_2      = go_v[1];
   assign go_3      = go_v[2];
   assign kill_1    = kill_v[0];
   assign kill_2    = kill_v[1];
   assign kill_3    = kill_v[2];
   assign busy      = busy_v;
   assign state_dbg = {ch_state[2], ch_state[1], ch_state[0]};

   // Clear takes priority over a simultaneous timeout set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_ltchd <= 1'b0;
      end else if (kill_clr) begin
         timeout_ltchd <= 1'b0;
      end else if (|tkill_v) begin
         timeout_ltchd <= 1'b1;
      end
   end

endmodule

// File: tb/tb_go_initiator_3.sv
// Bench for go_initiator_3: directed scenarios plus random traffic, all checked
// against a cycle-indexed transaction model (go cycle, kill cycle, timeout age).
module tb_go_initiator_3;
   import go_initiator_3_pkg::*;

   localparam int T = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] req = 3'b000;
   logic       abort = 1'b0;
   logic       done_1 = 1'b0, done_2 = 1'b0, done_3 = 1'b0;
   logic       kill_clr = 1'b0;
   logic       go_1, go_2, go_3, kill_1, kill_2, kill_3;
   logic [2:0] busy;
   logic       timeout_ltchd;
   logic [5:0] state_dbg;

   go_initiator_3 #(.TIMEOUT(T), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .req(req), .abort(abort),
      .done_1(done_1), .done_2(done_2), .done_3(done_3), .kill_clr(kill_clr),
      .go_1(go_1), .go_2(go_2), .go_3(go_3),
      .kill_1(kill_1), .kill_2(kill_2), .kill_3(kill_3),
      .busy(busy), .timeout_ltchd(timeout_ltchd), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   // Model: a channel is either free or owns a transaction whose go cycle is
   // known; WAIT occupies cycles go+1 .. go+T, a kill lands one cycle later.
   bit m_busy [3];
   int m_go   [3];
   int m_kill [3];
   int m_to   [3];
   bit m_flag;

   logic [31:0] exp_q[$];

   function automatic logic [9:0] exp_vec();
      logic [2:0] g, k, b;
      for (int i = 0; i < 3; i++) begin
         g[i] = m_busy[i] && (m_go[i] == cyc);
         k[i] = m_busy[i] && (m_kill[i] == cyc);
         b[i] = m_busy[i];
      end
      return {g, k, b, m_flag};
   endfunction

   function automatic logic [9:0] obs_vec();
      return {go_3, go_2, go_1, kill_3, kill_2, kill_1, busy, timeout_ltchd};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_busy[i] = 1'b0;
         m_go[i]   = -100;
         m_kill[i] = -100;
         m_to[i]   = -100;
      end
      m_flag = 1'b0;
   endtask

   task automatic model_update();
      logic [2:0] d;
      bit any_to;
      d = {done_3, done_2, done_1};
      if (!reset) begin
         model_reset();
         return;
      end
      any_to = 1'b0;
      for (int i = 0; i < 3; i++) if (m_to[i] == cyc) any_to = 1'b1;
      if (kill_clr) m_flag = 1'b0;
      else if (any_to) m_flag = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (!m_busy[i]) begin
            if (req[i]) begin
               m_busy[i] = 1'b1;
               m_go[i]   = cyc + 1;
               m_kill[i] = -100;
            end
         end else if (m_kill[i] == cyc) begin
            m_busy[i] = 1'b0;
         end else if (cyc > m_go[i] && m_kill[i] < 0) begin
            if (d[i]) m_busy[i] = 1'b0;
            else if (abort) m_kill[i] = cyc + 1;
            else if (cyc - m_go[i] == T) begin
               m_kill[i] = cyc + 1;
               m_to[i]   = cyc + 1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic settle();
      req = 3'b000; abort = 1'b0; done_1 = 1'b0; done_2 = 1'b0; done_3 = 1'b0;
      repeat (T + 4) tick();
      kill_clr = 1'b1;
      tick();
      kill_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_reset();
      repeat (2) tick();
      n_checks++;
      if (obs_vec() !== 10'd0) begin
         n_fails++;
         $display("FAIL reset_state: got %b want %b", obs_vec(), 10'd0);
      end
      reset = 1'b1;
      tick();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL reset_release: got %b want %b", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_done_early();
      int n_go = 0, n_kill = 0;
      req = 3'b001;
      tick();
      req = 3'b000;
      for (int c = 0; c < 12; c++) begin
         if (c == 4) done_1 = 1'b1;
         else done_1 = 1'b0;
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fails++;
            $display("FAIL done_early cyc %0d: got %b want %b", cyc, obs_vec(), exp_vec());
         end
         n_go += int'(go_1);
         n_kill += int'(kill_1);
         tick();
      end
      done_1 = 1'b0;
      n_checks++;
      if (n_go != 1 || n_kill != 0 || busy[0] !== 1'b0 || timeout_ltchd !== 1'b0) begin
         n_fails++;
         $display("FAIL done_early_summary: go=%0d kill=%0d busy0=%b flag=%b want 1 0 0 0",
                  n_go, n_kill, busy[0], timeout_ltchd);
      end
      settle();
   endtask

   task automatic test_timeout();
      int g, k = -1;
      req = 3'b010;
      tick();
      req = 3'b000;
      g = cyc;
      for (int c = 0; c < T + 5; c++) begin
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fails++;
            $display("FAIL timeout cyc %0d: got %b want %b", cyc, obs_vec(), exp_vec());
         end
         if (kill_2 === 1'b1) k = cyc;
         tick();
      end
      n_checks++;
      if (k - g != T + 1 || timeout_ltchd !== 1'b1) begin
         n_fails++;
         $display("FAIL timeout_latency: kill-go=%0d flag=%b want %0d 1", k - g, timeout_ltchd, T + 1);
      end
      kill_clr = 1'b1;
      tick();
      kill_clr = 1'b0;
      n_checks++;
      if (timeout_ltchd !== 1'b0) begin
         n_fails++;
         $display("FAIL timeout_clear: got %b want 0", timeout_ltchd);
      end
      settle();
   endtask

   task automatic test_abort();
      req = 3'b111;
      tick();
      req = 3'b000;
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      n_checks++;
      if ({kill_3, kill_2, kill_1} !== 3'b111 || obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL abort_kill: got %b want %b", obs_vec(), exp_vec());
      end
      repeat (3) tick();
      n_checks++;
      if (obs_vec() !== exp_vec() || timeout_ltchd !== 1'b0) begin
         n_fails++;
         $display("FAIL abort_after: got %b want %b", obs_vec(), exp_vec());
      end
      settle();
   endtask

   task automatic test_coincident();
      int g;
      int n_kill = 0;
      req = 3'b100;
      tick();
      req = 3'b000;
      g = cyc;
      while (cyc < g + T) tick();
      done_3 = 1'b1;
      tick();
      done_3 = 1'b0;
      repeat (4) begin
         n_kill += int'(kill_3);
         tick();
      end
      n_checks++;
      if (n_kill != 0 || timeout_ltchd !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL done_vs_timeout: kills=%0d flag=%b got %b want %b",
                  n_kill, timeout_ltchd, obs_vec(), exp_vec());
      end
      req = 3'b001;
      tick();
      req = 3'b000;
      g = cyc;
      while (cyc < g + T + 1) tick();
      kill_clr = 1'b1;
      tick();
      kill_clr = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (timeout_ltchd !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL clear_vs_set: flag=%b got %b want %b", timeout_ltchd, obs_vec(), exp_vec());
      end
      settle();
   endtask

   task automatic test_back_to_back();
      int g0;
      req = 3'b111;
      tick();
      g0 = cyc;
      exp_q.delete();
      for (int k = 0; g0 + 19 * k < g0 + 60; k++) exp_q.push_back(32'(g0 + 19 * k));
      for (int c = 0; c < 60; c++) begin
         n_checks++;
         if (obs_vec() !== exp_vec() || ({go_3, go_2, go_1} & {kill_3, kill_2, kill_1}) != 3'b000) begin
            n_fails++;
            $display("FAIL b2b cyc %0d: got %b want %b", cyc, obs_vec(), exp_vec());
         end
         if (go_1 === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0 || exp_q[0] != 32'(cyc)) begin
               n_fails++;
               $display("FAIL b2b_go_spacing: got cycle %0d want %0d", cyc,
                        exp_q.size() ? int'(exp_q[0]) : -1);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
         tick();
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL b2b_go_count: got %0d missing want 0", exp_q.size());
      end
      settle();
   endtask

   task automatic test_reset_mid();
      int n_kill = 0;
      req = 3'b001;
      tick();
      req = 3'b000;
      repeat (6) tick();
      reset = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (busy !== 3'b000 || obs_vec() !== 10'd0) begin
         n_fails++;
         $display("FAIL reset_async: got %b want %b", obs_vec(), 10'd0);
      end
      repeat (2) tick();
      reset = 1'b1;
      repeat (T + 6) begin
         n_kill += int'(kill_1);
         tick();
      end
      req = 3'b001;
      tick();
      req = 3'b000;
      n_checks++;
      if (n_kill != 0 || go_1 !== 1'b1 || obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL reset_mid: kills=%0d go1=%b got %b want %b", n_kill, go_1, obs_vec(), exp_vec());
      end
      settle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 3; i++) req[i] = ($urandom_range(0, 3) == 0);
         done_1   = ($urandom_range(0, 15) == 0);
         done_2   = ($urandom_range(0, 15) == 0);
         done_3   = ($urandom_range(0, 15) == 0);
         abort    = ($urandom_range(0, 39) == 0);
         kill_clr = ($urandom_range(0, 29) == 0);
         tick();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fails++;
            $display("FAIL random cyc %0d: got %b want %b", cyc, obs_vec(), exp_vec());
         end
      end
      kill_clr = 1'b0;
      settle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_done_early();
      test_timeout();
      test_abort();
      test_coincident();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
